// File: rtl/range_counter.sv
// rtl/range_counter.sv - bounded up/down counter with load clamping and saturate/wrap modes
module range_counter #(
    parameter int WIDTH = 32,
    parameter int MIN   = 8,
    parameter int MAX   = 64,
    parameter int INIT  = 8,
    parameter bit WRAP  = 1'b0
) (
    input  logic             Clk_i,
    input  logic             Reset_i,
    input  logic             En_i,
    input  logic             Up_i,
    input  logic             Load_i,
    input  logic [WIDTH-1:0] LoadData_i,
    output logic [WIDTH-1:0] Data_o,
    output logic             AtMin_o,
    output logic             AtMax_o,
    output logic             Wrap_o,
    output logic             LoadErr_o
);

    if (MIN < 0 || MIN >= MAX || INIT < MIN || INIT > MAX ||
        (WIDTH < 63 && longint'(MAX) > ((longint'(1) << WIDTH) - 1))) begin : g_param_check
        $error("range_counter: illegal MIN/MAX/INIT/WIDTH combination");
    end

    localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);

    logic [WIDTH-1:0] data_q, data_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;

    // Increment/decrement only happen strictly inside the bounds, so the
    // arithmetic can never overflow the WIDTH-bit register.
    always_comb begin
        data_d     = data_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (Load_i) begin
            if (LoadData_i < MIN_W) begin
                data_d     = MIN_W;
                load_err_d = 1'b1;
            end else if (LoadData_i > MAX_W) begin
                data_d     = MAX_W;
                load_err_d = 1'b1;
            end else begin
                data_d = LoadData_i;
            end
        end else if (En_i) begin
            if (Up_i) begin
                if (data_q < MAX_W) begin
                    data_d = data_q + 1'b1;
                end else if (WRAP) begin
                    data_d = MIN_W;
                    wrap_d = 1'b1;
                end
            end else begin
                if (data_q > MIN_W) begin
                    data_d = data_q - 1'b1;
                end else if (WRAP) begin
                    data_d = MAX_W;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            data_q     <= INIT_W;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign Data_o    = data_q;
    assign AtMin_o   = (data_q == MIN_W);
    assign AtMax_o   = (data_q == MAX_W);
    assign Wrap_o    = wrap_q;
    assign LoadErr_o = load_err_q;

endmodule

// File: tb/tb_range_counter.sv
// tb/tb_range_counter.sv - randomized check of saturating and wrapping range_counter against a reference model
module tb_range_counter;

    localparam int     WIDTH = 32;
    localparam longint MIN   = 8;
    localparam longint MAX   = 64;
    localparam longint INIT  = 8;
    localparam longint SPAN  = MAX - MIN + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             en = 1'b0;
    logic             up = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_data = '0;

    logic [WIDTH-1:0] data_s, data_w;
    logic             at_min_s, at_max_s, wrap_s, err_s;
    logic             at_min_w, at_max_w, wrap_w, err_w;

    int vectors = 0;
    int miscompares = 0;

    // Model state, index 0 = saturating instance, 1 = wrapping instance
    longint m_val [2];
    bit     m_wrap[2];
    bit     m_err [2];

    always #5 clk = ~clk;

    range_counter #(.WIDTH(WIDTH), .MIN(8), .MAX(64), .INIT(8), .WRAP(1'b0)) dut_sat (
        .Clk_i(clk), .Reset_i(reset), .En_i(en), .Up_i(up), .Load_i(load),
        .LoadData_i(load_data), .Data_o(data_s), .AtMin_o(at_min_s),
        .AtMax_o(at_max_s), .Wrap_o(wrap_s), .LoadErr_o(err_s)
    );

    range_counter #(.WIDTH(WIDTH), .MIN(8), .MAX(64), .INIT(8), .WRAP(1'b1)) dut_wrap (
        .Clk_i(clk), .Reset_i(reset), .En_i(en), .Up_i(up), .Load_i(load),
        .LoadData_i(load_data), .Data_o(data_w), .AtMin_o(at_min_w),
        .AtMax_o(at_max_w), .Wrap_o(wrap_w), .LoadErr_o(err_w)
    );

    task automatic expect_eq(input string tag, input longint obs, input longint exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int m, input bit is_wrap);
        longint nxt;
        m_wrap[m] = 1'b0;
        m_err[m]  = 1'b0;
        if (reset) begin
            m_val[m] = INIT;
        end else if (load) begin
            if (longint'(load_data) < MIN) begin
                m_val[m] = MIN; m_err[m] = 1'b1;
            end else if (longint'(load_data) > MAX) begin
                m_val[m] = MAX; m_err[m] = 1'b1;
            end else begin
                m_val[m] = longint'(load_data);
            end
        end else if (en) begin
            nxt = up ? m_val[m] + 1 : m_val[m] - 1;
            if (nxt >= MIN && nxt <= MAX) begin
                m_val[m] = nxt;
            end else if (is_wrap) begin
                m_val[m]  = MIN + (((nxt - MIN) % SPAN) + SPAN) % SPAN;
                m_wrap[m] = 1'b1;
            end
        end
    endtask

    task automatic apply(input bit r, input bit ld, input longint ldata, input bit e, input bit u);
        @(negedge clk);
        reset = r; load = ld; load_data = WIDTH'(ldata); en = e; up = u;
        model_step(0, 1'b0);
        model_step(1, 1'b1);
        @(posedge clk);
        #1;
        expect_eq("sat_data",    longint'(data_s), m_val[0]);
        expect_eq("sat_at_min",  longint'(at_min_s), longint'(m_val[0] == MIN));
        expect_eq("sat_at_max",  longint'(at_max_s), longint'(m_val[0] == MAX));
        expect_eq("sat_wrap",    longint'(wrap_s), longint'(m_wrap[0]));
        expect_eq("sat_lderr",   longint'(err_s), longint'(m_err[0]));
        expect_eq("wrap_data",   longint'(data_w), m_val[1]);
        expect_eq("wrap_at_min", longint'(at_min_w), longint'(m_val[1] == MIN));
        expect_eq("wrap_at_max", longint'(at_max_w), longint'(m_val[1] == MAX));
        expect_eq("wrap_wrap",   longint'(wrap_w), longint'(m_wrap[1]));
        expect_eq("wrap_lderr",  longint'(err_w), longint'(m_err[1]));
    endtask

    initial begin
        longint ld_val;
        m_val[0] = INIT; m_val[1] = INIT;

        apply(1, 0, 0, 0, 0);
        expect_eq("reset_value", longint'(data_s), 8);

        // Count up from 8 for 60 cycles: saturating instance must end holding 64
        for (int i = 0; i < 60; i++) apply(0, 0, 0, 1, 1);
        expect_eq("sat_hold_64", longint'(data_s), 64);

        // Wrap up from 64
        apply(0, 1, 64, 0, 0);
        apply(0, 0, 0, 1, 1);
        expect_eq("wrap_up_to_min", longint'(data_w), 8);
        expect_eq("wrap_up_pulse", longint'(wrap_w), 1);
        apply(0, 0, 0, 0, 1);
        expect_eq("wrap_pulse_one_cycle", longint'(wrap_w), 0);

        // Out-of-range and in-range loads with enable asserted
        apply(0, 1, 3, 1, 1);
        expect_eq("load_low_clamp", longint'(data_s), 8);
        apply(0, 1, 40, 1, 1);
        expect_eq("load_mid", longint'(data_s), 40);
        apply(0, 1, 100, 1, 0);
        expect_eq("load_high_clamp", longint'(data_s), 64);
        apply(0, 1, 64'hFFFF_FFFF, 1, 0);
        apply(0, 1, 0, 0, 0);

        // Decrement at MIN
        apply(0, 0, 0, 1, 0);
        expect_eq("wrap_down_to_max", longint'(data_w), 64);
        expect_eq("sat_down_hold_min", longint'(data_s), 8);

        // Reset coincident with load and a pending wrap
        apply(0, 1, 64, 0, 0);
        apply(1, 1, 40, 1, 1);
        expect_eq("reset_over_load", longint'(data_w), 8);
        apply(0, 0, 0, 1, 1);

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0:       ld_val = longint'($urandom);
                1, 2:    ld_val = longint'($urandom_range(0, 7));
                3:       ld_val = longint'($urandom_range(65, 200));
                default: ld_val = longint'($urandom_range(8, 64));
            endcase
            apply($urandom_range(0, 40) == 0, $urandom_range(0, 7) == 0, ld_val,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/range_counter.md
RANGE_COUNTER -- requirements
Module: range_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: counter and load data width in bits.
REQ-002 SHALL have parameter MIN, default 8: lowest legal count value.
REQ-003 SHALL have parameter MAX, default 64: highest legal count value.
REQ-004 SHALL have parameter INIT, default 8: count value after reset.
REQ-005 SHALL have parameter WRAP, default 0: 0 = saturate at bounds, 1 = wrap to opposite bound.
REQ-006 SHALL have port Clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port Reset_i, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port En_i, input, 1: count enable.
REQ-009 SHALL have port Up_i, input, 1: direction; 1 = increment, 0 = decrement.
REQ-010 SHALL have port Load_i, input, 1: load request.
REQ-011 SHALL have port LoadData_i, input, WIDTH: value to load.
REQ-012 SHALL have port Data_o, output, WIDTH: registered count value.
REQ-013 SHALL have port AtMin_o, output, 1: high while Data_o == MIN.
REQ-014 SHALL have port AtMax_o, output, 1: high while Data_o == MAX.
REQ-015 SHALL have port Wrap_o, output, 1: one-cycle registered pulse on a wrap event.
REQ-016 SHALL have port LoadErr_o, output, 1: one-cycle registered pulse on an out-of-range load.

Function
REQ-017 SHALL require MIN < MAX, MIN <= INIT <= MAX, MAX <= 2**WIDTH-1; elaboration SHALL fail otherwise.
REQ-018 SHALL update Data_o, Wrap_o and LoadErr_o only on the Clk_i rising edge; latency from input to Data_o is 1 cycle.
REQ-019 SHALL apply priority per cycle: Reset_i > Load_i > En_i > hold.
REQ-020 SHALL, on Load_i with MIN <= LoadData_i <= MAX, set Data_o = LoadData_i, LoadErr_o = 0.
REQ-021 SHALL, on Load_i with LoadData_i < MIN, set Data_o = MIN and pulse LoadErr_o; with LoadData_i > MAX, set Data_o = MAX and pulse LoadErr_o.
REQ-022 SHALL ignore En_i and Up_i in any cycle where Load_i is high.
REQ-023 SHALL, on En_i & Up_i with Data_o < MAX, set Data_o = Data_o + 1.
REQ-024 SHALL, on En_i & !Up_i with Data_o > MIN, set Data_o = Data_o - 1.
REQ-025 SHALL, on En_i & Up_i at Data_o == MAX: WRAP=0 hold MAX, no pulse; WRAP=1 set Data_o = MIN and pulse Wrap_o.
REQ-026 SHALL, on En_i & !Up_i at Data_o == MIN: WRAP=0 hold MIN, no pulse; WRAP=1 set Data_o = MAX and pulse Wrap_o.
REQ-027 SHALL hold Data_o when En_i, Load_i and Reset_i are all low.
REQ-028 SHALL drive Wrap_o and LoadErr_o low in every cycle not meeting REQ-021/025/026; never high simultaneously.
REQ-029 SHALL derive AtMin_o and AtMax_o combinationally from registered Data_o only.
REQ-030 SHALL never present Data_o outside [MIN, MAX] in any cycle, including at WIDTH boundaries (no arithmetic overflow/underflow).
REQ-031 SHALL, with default parameters and En_i=1, Up_i=1, Load_i=0, count 8..64 and then hold at 64.

Reset
REQ-032 SHALL, when Reset_i is high at a rising edge, set Data_o = INIT, Wrap_o = 0, LoadErr_o = 0, regardless of other inputs.
REQ-033 SHALL, on reset asserted mid-count or coincident with Load_i/wrap, discard the pending operation; no pulse in the following cycle.
REQ-034 SHALL resume normal operation in the first cycle after Reset_i deasserts.

Verification
REQ-035 SHALL cover: defaults, reset then En_i=1, Up_i=1 for 60 cycles -> Data_o 8,9,...,64, holds 64, AtMax_o=1, Wrap_o never 1.
REQ-036 SHALL cover: WRAP=1, Data_o=64, En_i=1, Up_i=1 -> Data_o=8 next cycle, Wrap_o=1 for exactly one cycle, AtMin_o=1.
REQ-037 SHALL cover: WRAP=1, Data_o=8, En_i=1, Up_i=0 -> Data_o=64, Wrap_o pulse; WRAP=0 same stimulus -> Data_o stays 8, no pulse.
REQ-038 SHALL cover: Load_i=1 with LoadData_i=3, 40, 100 (En_i=1) -> Data_o=8 with LoadErr_o, 40 without, 64 with LoadErr_o.
REQ-039 SHALL cover: Reset_i=1 coincident with Load_i=1, LoadData_i=40 at Data_o=64, WRAP=1, En_i=1 -> Data_o=8, Wrap_o=0, LoadErr_o=0.
REQ-040 SHALL cover formally: Data_o in [MIN,MAX] always; !Reset_i & !Load_i & En_i & Up_i & Data_o<MAX implies next Data_o == past Data_o + 1.
